// File: rtl/local_mean_pkg.sv
// +--------------------------------------------------------------------+
// | local_mean_pkg                                                     |
// | Shared types and constants for the 3x3 local-mean threshold block. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package local_mean_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int TAPS        = 9;
    localparam int RECIP9      = 7282;
    localparam int RECIP_SHIFT = 16;
    localparam int ROUND_BIAS  = 4;
    localparam int ACC_BITS    = 12;
    localparam int PROD_BITS   = 26;
    localparam int TAP_BITS    = 4;

    // Neighbourhood offset encoded as a 2-bit two's-complement value
    typedef logic [1:0] offset_t;
    localparam offset_t OFF_NEG  = 2'b11;
    localparam offset_t OFF_ZERO = 2'b00;
    localparam offset_t OFF_POS  = 2'b01;

    // Taps sweep dy outer, dx inner: k = 3*(dy+1) + (dx+1)
    function automatic offset_t tap_dy(input logic [TAP_BITS-1:0] k);
        offset_t result;
        case (k)
            4'd0, 4'd1, 4'd2: result = OFF_NEG;
            4'd3, 4'd4, 4'd5: result = OFF_ZERO;
            default:          result = OFF_POS;
        endcase
        return result;
    endfunction

    function automatic offset_t tap_dx(input logic [TAP_BITS-1:0] k);
        offset_t result;
        case (k)
            4'd0, 4'd3, 4'd6: result = OFF_NEG;
            4'd1, 4'd4, 4'd7: result = OFF_ZERO;
            default:          result = OFF_POS;
        endcase
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/local_mean_clamp_offset.sv
// +--------------------------------------------------------------------+
// | clamp_offset                                                       |
// | Applies a -1/0/+1 offset to a coordinate, clamped to [0, limit].   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module clamp_offset
    import local_mean_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] coord,
    input  offset_t         offset,
    input  logic [BITS-1:0] limit,
    output logic [BITS-1:0] clamped
);

    always_comb begin
        clamped = coord;
        if (offset == OFF_NEG) begin
            if (coord != '0) begin
                clamped = coord - BITS'(1);
            end
        end else if (offset == OFF_POS) begin
            if (coord != limit) begin
                clamped = coord + BITS'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/local_mean.sv
// +--------------------------------------------------------------------+
// | local_mean                                                         |
// | Per-pixel 3x3 mean (edge-replicated) threshold map generator.      |
// | Optional macro LOCAL_MEAN_ROUND_EN selects round-to-nearest mean.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module local_mean
    import local_mean_pkg::*;
#(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8,
    parameter int WIDTH       = 2 ** WIDTH_BITS,
    parameter int HEIGHT      = 2 ** HEIGHT_BITS
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   iStart,
    output logic [WIDTH_BITS-1:0]  oImageCol,
    output logic [HEIGHT_BITS-1:0] oImageRow,
    input  logic [7:0]             iImageData,
    output logic [WIDTH_BITS-1:0]  oThresholdCol,
    output logic [HEIGHT_BITS-1:0] oThresholdRow,
    output logic [7:0]             oThresholdData,
    output logic                   oThresholdWren,
    output logic                   busy,
    output logic                   finished
);

    localparam logic [WIDTH_BITS-1:0]  c_x_last   = WIDTH_BITS'(WIDTH - 1);
    localparam logic [HEIGHT_BITS-1:0] c_y_last   = HEIGHT_BITS'(HEIGHT - 1);
    localparam logic [TAP_BITS-1:0]    c_tap_last = TAP_BITS'(TAPS - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [TAP_BITS-1:0]    r_tap;
    logic [WIDTH_BITS-1:0]  r_x;
    logic [HEIGHT_BITS-1:0] r_y;
    logic [ACC_BITS-1:0]    r_acc;

    logic                   w_start_ok;
    logic                   w_last_pixel;
    logic [ACC_BITS-1:0]    w_data_ext;
    logic [WIDTH_BITS-1:0]  w_tap_col;
    logic [HEIGHT_BITS-1:0] w_tap_row;
    logic [ACC_BITS-1:0]    w_sum;
    logic [PROD_BITS-1:0]   w_product;
    logic                   w_unused_bits;

    assign w_start_ok   = iStart && ((r_state == IDLE) || (r_state == DONE));
    assign w_last_pixel = (r_x == c_x_last) && (r_y == c_y_last);
    assign w_data_ext   = ACC_BITS'(iImageData);

    clamp_offset #(
        .BITS (HEIGHT_BITS)
    ) u_clamp_row (
        .coord   (r_y),
        .offset  (tap_dy(r_tap)),
        .limit   (c_y_last),
        .clamped (w_tap_row)
    );

    clamp_offset #(
        .BITS (WIDTH_BITS)
    ) u_clamp_col (
        .coord   (r_x),
        .offset  (tap_dx(r_tap)),
        .limit   (c_x_last),
        .clamped (w_tap_col)
    );

    // Division by 9 through a fixed-point reciprocal; exact over the whole sum range
`ifdef LOCAL_MEAN_ROUND_EN
    assign w_sum = r_acc + ACC_BITS'(ROUND_BIAS);
`else
    assign w_sum = r_acc;
`endif
    assign w_product     = PROD_BITS'(w_sum) * PROD_BITS'(RECIP9);
    assign w_unused_bits = ^{w_product[RECIP_SHIFT-1:0], w_product[PROD_BITS-1:RECIP_SHIFT+8]};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_tap   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE, DONE: begin
                    if (iStart) begin
                        r_tap <= '0;
                        r_x   <= '0;
                        r_y   <= '0;
                        r_acc <= '0;
                    end
                end
                READ: begin
                    // Data for tap k-1 arrives while tap k is addressed
                    if (r_tap != '0) begin
                        r_acc <= r_acc + w_data_ext;
                    end
                    r_tap <= r_tap + TAP_BITS'(1);
                end
                DRAIN: begin
                    r_acc <= r_acc + w_data_ext;
                end
                WRITE: begin
                    r_acc <= '0;
                    r_tap <= '0;
                    if (!w_last_pixel) begin
                        if (r_x == c_x_last) begin
                            r_x <= '0;
                            r_y <= r_y + HEIGHT_BITS'(1);
                        end else begin
                            r_x <= r_x + WIDTH_BITS'(1);
                        end
                    end
                end
                default: begin
                    r_tap <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_state_next   = r_state;
        oImageCol      = '0;
        oImageRow      = '0;
        oThresholdCol  = '0;
        oThresholdRow  = '0;
        oThresholdData = '0;
        oThresholdWren = 1'b0;
        busy           = 1'b0;
        finished       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_state_next = READ;
                end
            end
            READ: begin
                busy      = 1'b1;
                oImageCol = w_tap_col;
                oImageRow = w_tap_row;
                if (r_tap == c_tap_last) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy         = 1'b1;
                w_state_next = WRITE;
            end
            WRITE: begin
                busy           = 1'b1;
                oThresholdWren = 1'b1;
                oThresholdCol  = r_x;
                oThresholdRow  = r_y;
                oThresholdData = w_product[RECIP_SHIFT +: 8];
                w_state_next   = w_last_pixel ? DONE : READ;
            end
            DONE: begin
                finished = 1'b1;
                if (w_start_ok) begin
                    w_state_next = READ;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_local_mean.sv
// +--------------------------------------------------------------------+
// | tb_local_mean                                                      |
// | Self-checking bench: directed tables plus random images vs model.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_local_mean;

    localparam int WB   = 2;
    localparam int HB   = 2;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic          clock;
    logic          reset_n;
    logic          iStart;
    logic [WB-1:0] oImageCol;
    logic [HB-1:0] oImageRow;
    logic [7:0]    iImageData;
    logic [WB-1:0] oThresholdCol;
    logic [HB-1:0] oThresholdRow;
    logic [7:0]    oThresholdData;
    logic          oThresholdWren;
    logic          busy;
    logic          finished;

    logic [7:0] img [H][W];
    int         got [H][W];
    int         errors = 0;
    int         checks = 0;

    local_mean #(
        .WIDTH_BITS  (WB),
        .HEIGHT_BITS (HB)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .iStart         (iStart),
        .oImageCol      (oImageCol),
        .oImageRow      (oImageRow),
        .iImageData     (iImageData),
        .oThresholdCol  (oThresholdCol),
        .oThresholdRow  (oThresholdRow),
        .oThresholdData (oThresholdData),
        .oThresholdWren (oThresholdWren),
        .busy           (busy),
        .finished       (finished)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Registered-read image memory
    always @(posedge clock) iImageData <= img[oImageRow][oImageCol];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    // Reference: sum the replicated 3x3 window and divide
    function automatic int model_at(input int x, input int y);
        int s;
        s = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                s += int'(img[clampi(y + dy, H - 1)][clampi(x + dx, W - 1)]);
`ifdef LOCAL_MEAN_ROUND_EN
        s += 4;
`endif
        return s / 9;
    endfunction

    task automatic fill(input int pat);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                case (pat)
                    0:       img[y][x] = 8'd100;
                    1:       img[y][x] = (x == 0 && y == 0) ? 8'd255 : 8'd0;
                    2:       img[y][x] = (x == 1 && y == 1) ? 8'd8 : 8'd0;
                    3:       img[y][x] = 8'd255;
                    default: img[y][x] = 8'($urandom_range(0, 255));
                endcase
    endtask

    // poke: cycle with a stray iStart; rst_at: cycle with reset_n low (-1 = none)
    task automatic run_pass(input int poke, input int rst_at);
        int  nw;
        int  n;
        bit  stop;
        bit  aborted;
        nw      = 0;
        stop    = 0;
        aborted = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                got[y][x] = -1;
        @(negedge clock);
        iStart = 1'b1;
        n = 0;
        while (!stop) begin
            @(negedge clock);
            n++;
            if (oThresholdWren) begin
                if (aborted) begin
                    check("no_write_after_reset", 1, 0);
                end else begin
                    check("write_cycle", n, 11 * (nw + 1));
                    check("write_addr", int'(oThresholdRow) * W + int'(oThresholdCol), nw);
                    check("write_data", int'(oThresholdData),
                          model_at(int'(oThresholdCol), int'(oThresholdRow)));
                    got[oThresholdRow][oThresholdCol] = int'(oThresholdData);
                    nw++;
                end
            end
            if (n == 1) begin
                check("busy_after_start", int'(busy), 1);
                check("finished_cleared", int'(finished), 0);
            end
            if (rst_at >= 0 && n == rst_at + 1) begin
                check("reset_outputs_zero",
                      int'({oImageCol, oImageRow, oThresholdCol, oThresholdRow,
                            oThresholdData, oThresholdWren, busy, finished}), 0);
            end
            if (aborted && n >= rst_at + 30) begin
                check("aborted_stays_idle", int'({busy, finished}), 0);
                stop = 1;
            end else if (finished && !aborted) begin
                check("done_cycle", n, 11 * NPIX + 1);
                check("busy_low_at_done", int'(busy), 0);
                check("write_count", nw, NPIX);
                iStart = 1'b0;
                repeat (3) @(negedge clock);
                check("finished_sticky", int'({finished, busy}), 2);
                stop = 1;
            end else if (n > 11 * NPIX + 20) begin
                check("pass_timeout", 0, 1);
                stop = 1;
            end
            iStart  = (n == poke) ? 1'b1 : 1'b0;
            reset_n = (n == rst_at) ? 1'b0 : 1'b1;
            if (n == rst_at) aborted = 1;
        end
        iStart  = 1'b0;
        reset_n = 1'b1;
    endtask

    typedef struct {
        int pat;
        int x;
        int y;
        int exp_floor;
        int exp_round;
    } vec_t;

    vec_t vecs [15];

    initial begin
        vecs[0]  = '{0, 0, 0, 100, 100};
        vecs[1]  = '{0, 3, 3, 100, 100};
        vecs[2]  = '{1, 0, 0, 113, 113};
        vecs[3]  = '{1, 1, 0, 56, 57};
        vecs[4]  = '{1, 1, 1, 28, 28};
        vecs[5]  = '{1, 2, 2, 0, 0};
        vecs[6]  = '{2, 1, 1, 0, 1};
        vecs[7]  = '{2, 0, 0, 0, 1};
        vecs[8]  = '{2, 2, 2, 0, 1};
        vecs[9]  = '{2, 2, 0, 0, 1};
        vecs[10] = '{2, 3, 3, 0, 0};
        vecs[11] = '{3, 0, 0, 255, 255};
        vecs[12] = '{3, 2, 1, 255, 255};
        vecs[13] = '{3, 3, 3, 255, 255};
        vecs[14] = '{1, 3, 3, 0, 0};

        reset_n = 1'b0;
        iStart  = 1'b0;
        fill(0);
        repeat (3) @(negedge clock);
        check("reset_outputs",
              int'({oImageCol, oImageRow, oThresholdCol, oThresholdRow,
                    oThresholdData, oThresholdWren, busy, finished}), 0);
        reset_n = 1'b1;
        @(negedge clock);

        for (int p = 0; p < 4; p++) begin
            fill(p);
            run_pass(-1, -1);
            for (int i = 0; i < 15; i++) begin
                if (vecs[i].pat == p) begin
`ifdef LOCAL_MEAN_ROUND_EN
                    check("table_pixel", got[vecs[i].y][vecs[i].x], vecs[i].exp_round);
`else
                    check("table_pixel", got[vecs[i].y][vecs[i].x], vecs[i].exp_floor);
`endif
                end
            end
        end

        fill(0);
        run_pass(30, -1);

        for (int r = 0; r < 3; r++) begin
            fill(4);
            run_pass(-1, -1);
        end

        fill(4);
        run_pass(-1, 50);
        fill(4);
        run_pass(-1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
